// File: rtl/mux_arb_pkg.sv
// Shared constants, FSM state type and one-hot helper for the 32-way
// round-robin mux arbiter.
package mux_arb_pkg;

    localparam int N     = 32;
    localparam int SEL_W = 5;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    function automatic logic [N-1:0] onehot(input logic [SEL_W-1:0] idx);
        logic [N-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/mux32to1.sv
// 32:1 single-bit mux datapath shared by the arbiter's requesters.
module mux32to1 (
    input  logic [31:0] I,
    input  logic [4:0]  S,
    output logic        Y
);

    assign Y = I[S];

endmodule

// File: rtl/rr_pick.sv
// Round-robin winner search: first set req bit at index >= ptr, wrapping 31->0.
module rr_pick
    import mux_arb_pkg::*;
(
    input  logic [N-1:0]     req,
    input  logic [SEL_W-1:0] ptr,
    output logic             any,
    output logic [SEL_W-1:0] idx
);

    logic [N-1:0]     rot;
    logic [SEL_W-1:0] enc;

    // Rotate so ptr lands at bit 0; the lowest set bit is then the winner.
    assign rot = N'({req, req} >> ptr);

    always_comb begin
        enc = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (rot[i]) enc = SEL_W'(i);
        end
    end

    assign any = |req;
    assign idx = enc + ptr;

endmodule

// File: rtl/mux32_rr_arbiter.sv
// Round-robin arbiter sharing the 32:1 mux; bursts capped at MAX_HOLD
// transfers per grant, with one idle bubble between grants.
module mux32_rr_arbiter
    import mux_arb_pkg::*;
#(
    parameter int MAX_HOLD = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] req,
    input  logic [31:0] I,
    input  logic        ready,
    output logic [4:0]  S,
    output logic [31:0] gnt,
    output logic        Y,
    output logic        valid,
    output logic        busy
);

    state_t           state;
    logic [SEL_W-1:0] ptr;
    logic [3:0]       cnt;
    logic             any;
    logic [SEL_W-1:0] win;
    logic             xfer;
    logic             last;

    rr_pick u_pick (
        .req (req),
        .ptr (ptr),
        .any (any),
        .idx (win)
    );

    mux32to1 u_mux (
        .I (I),
        .S (S),
        .Y (Y)
    );

    assign busy  = (state == GRANT);
    assign valid = busy & req[S];
    assign xfer  = valid & ready;
    assign last  = (cnt == 4'(MAX_HOLD - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            S     <= '0;
            gnt   <= '0;
            ptr   <= '0;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (any) begin
                        S     <= win;
                        gnt   <= onehot(win);
                        cnt   <= '0;
                        state <= GRANT;
                    end
                end
                GRANT: begin
                    // Dropped request or exhausted burst both hand the mux on;
                    // S is left pointing at the last grantee.
                    if (!req[S] || (xfer && last)) begin
                        state <= IDLE;
                        gnt   <= '0;
                        cnt   <= '0;
                        ptr   <= S + SEL_W'(1);
                    end else if (xfer) begin
                        cnt <= cnt + 4'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
